// File: rtl/pixseq_pkg.sv
// Shared types and defaults for the pixel sequencer: pixel width, FSM state encoding
// and the default frame geometry / watchdog limit.
package pixseq_pkg;

   localparam int unsigned PIX_W       = 12;
   localparam int unsigned DEF_IMG_W   = 160;
   localparam int unsigned DEF_IMG_H   = 120;
   localparam int unsigned DEF_ADDR_W  = 15;
   localparam int unsigned DEF_TIMEOUT = 4096;

   typedef logic [PIX_W-1:0] pix_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      PRESENT,
      WRITE,
      DRAIN
   } state_t;

endpackage

// File: rtl/pixel_sequencer_if.sv
// Pixel datapath bundle: shared ROM read port, processor handshake and framebuffer write port.
interface pixel_sequencer_if
   import pixseq_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
);

   logic [ADDR_W-1:0] img_addr;
   pix_t              img_data;
   pix_t              wm_data;
   pix_t              image_pix;
   pix_t              water_pix;
   logic              waiting;
   logic              done;
   pix_t              regout_pix;
   logic              fb_we;
   logic [ADDR_W-1:0] fb_addr;
   pix_t              fb_data;

   modport master (
      output img_addr, image_pix, water_pix, waiting, fb_we, fb_addr, fb_data,
      input  img_data, wm_data, done, regout_pix
   );

   modport slave (
      input  img_addr, image_pix, water_pix, waiting, fb_we, fb_addr, fb_data,
      output img_data, wm_data, done, regout_pix
   );

endinterface

// File: rtl/pixseq_watchdog.sv
// Per-pixel watchdog: counts enabled cycles after a clear and raises expire (registered)
// once TIMEOUT cycles have been counted; holds expire until the next clear or reset.
module pixseq_watchdog
   import pixseq_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
)(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count  <= '0;
         expire <= 1'b0;
      end else if (enable && !expire) begin
         count  <= count + CNT_W'(1);
         expire <= (count + CNT_W'(1)) == CNT_W'(TIMEOUT);
      end
   end

endmodule

// File: rtl/pixel_sequencer.sv
// Pixel sequencer: walks a frame, fetching image/watermark pixels, handing them to an external
// processor and writing its result to the framebuffer. Option: PIXEL_SEQUENCER_TIMEOUT_EN.
module pixel_sequencer
   import pixseq_pkg::*;
#(
   parameter int unsigned IMG_W   = DEF_IMG_W,
   parameter int unsigned IMG_H   = DEF_IMG_H,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   pixel_sequencer_if.master bus,
   output logic              busy,
   output logic              frame_done,
   output logic              timeout_err
);

   localparam int unsigned       NUM_PIX  = IMG_W * IMG_H;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIX - 1);

   // Scope that only exists for an unusable parameter set (frame larger than the address space, or zero timeout).
   if (TIMEOUT == 0 || (64'd1 << ADDR_W) < 64'(NUM_PIX)) begin : g_bad_config
   end

   state_t            state;
   logic [ADDR_W-1:0] index;

`ifdef PIXEL_SEQUENCER_TIMEOUT_EN
   logic wd_expire;

   pixseq_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (state == LOAD),
      .enable (state == PRESENT),
      .expire (wd_expire)
   );
`else
   assign timeout_err = 1'b0;
`endif

   // Frame FSM; every output is registered alongside the state transition that implies it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         index         <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         bus.img_addr  <= '0;
         bus.image_pix <= '0;
         bus.water_pix <= '0;
         bus.waiting   <= 1'b0;
         bus.fb_we     <= 1'b0;
         bus.fb_addr   <= '0;
         bus.fb_data   <= '0;
`ifdef PIXEL_SEQUENCER_TIMEOUT_EN
         timeout_err   <= 1'b0;
`endif
      end else begin
         bus.fb_we  <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state        <= FETCH;
                  index        <= '0;
                  bus.img_addr <= '0;
                  busy         <= 1'b1;
`ifdef PIXEL_SEQUENCER_TIMEOUT_EN
                  timeout_err  <= 1'b0;
`endif
               end
            end
            FETCH: state <= LOAD;
            LOAD: begin
               bus.image_pix <= bus.img_data;
               bus.water_pix <= bus.wm_data;
               bus.waiting   <= 1'b1;
               state         <= PRESENT;
            end
            PRESENT: begin
               if (bus.done) begin
                  bus.waiting <= 1'b0;
                  bus.fb_we   <= 1'b1;
                  bus.fb_addr <= index;
                  bus.fb_data <= bus.regout_pix;
                  state       <= WRITE;
               end
`ifdef PIXEL_SEQUENCER_TIMEOUT_EN
               else if (wd_expire) begin
                  bus.waiting <= 1'b0;
                  bus.fb_we   <= 1'b1;
                  bus.fb_addr <= index;
                  bus.fb_data <= bus.image_pix;
                  timeout_err <= 1'b1;
                  state       <= WRITE;
               end
`endif
            end
            WRITE: state <= DRAIN;
            // Hold here until the processor drops done so one result never produces two writes.
            DRAIN: begin
               if (!bus.done) begin
                  if (index == LAST_IDX) begin
                     frame_done   <= 1'b1;
                     busy         <= 1'b0;
                     index        <= '0;
                     bus.img_addr <= '0;
                     state        <= IDLE;
                  end else begin
                     index        <= index + ADDR_W'(1);
                     bus.img_addr <= index + ADDR_W'(1);
                     state        <= FETCH;
                  end
               end
            end
            default: begin
               busy        <= 1'b0;
               bus.waiting <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule
